mc_processor: RTL

- Multi-cycle, parametrised successor to the single-cycle processor top.
- Shares one external memory port for instruction fetch and data access, with a req/ready handshake so the memory may stall.
- Sequences each instruction through an FSM (IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT) with configurable data width and register count.
- Exposes the same debug observables (rd1, rd2, result, alu_result, alu_op, CMPFlag, PC) plus FSM state.

---
 rtl/mc_processor_pkg.sv | 59 +++++
 rtl/mc_regfile.sv | 32 +++
 rtl/mc_processor.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mc_processor_pkg.sv
// Shared definitions for the multi-cycle processor: opcodes, FSM encoding,
// ALU control codes and instruction field positions.
package mc_processor_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_ORR  = 4'h3;
    localparam logic [3:0] OP_LSL  = 4'h4;
    localparam logic [3:0] OP_CMP  = 4'h5;
    localparam logic [3:0] OP_LDR  = 4'h6;
    localparam logic [3:0] OP_STR  = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_LSL = 3'd4;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int RD_MSB  = 27;
    localparam int RD_LSB  = 24;
    localparam int RN_MSB  = 23;
    localparam int RN_LSB  = 20;
    localparam int RM_MSB  = 19;
    localparam int RM_LSB  = 16;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    // Opcodes outside this set decode as NOP.
    function automatic logic op_known(input logic [3:0] op);
        return (op <= OP_ADDI) || (op == OP_HALT);
    endfunction

    function automatic logic [2:0] alu_op_of(input logic [3:0] op);
        case (op)
            OP_SUB, OP_CMP: return ALU_SUB;
            OP_AND:         return ALU_AND;
            OP_ORR:         return ALU_ORR;
            OP_LSL:         return ALU_LSL;
            default:        return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// NREGS x DATA_W register file: two asynchronous read ports, one synchronous
// write port, asynchronous active-low clear.
module mc_regfile #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [AW-1:0]     ra1_i,
    input  logic [AW-1:0]     ra2_i,
    input  logic              we_i,
    input  logic [AW-1:0]     wa_i,
    input  logic [DATA_W-1:0] wd_i,
    output logic [DATA_W-1:0] rd1_o,
    output logic [DATA_W-1:0] rd2_o
);

    logic [DATA_W-1:0] regs_q [NREGS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (we_i) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = regs_q[ra1_i];
    assign rd2_o = regs_q[ra2_i];

endmodule

// File: rtl/mc_processor.sv
// Multi-cycle processor sharing one memory port for fetch and data access.
// Optional MC_PROCESSOR_PERF_EN adds cycle_cnt / instret performance counters.
module mc_processor
    import mc_processor_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] result,
    output logic [2:0]        alu_op,
    output logic              CMPFlag,
    output logic [31:0]       PC,
    output logic [2:0]        state,
    output logic              halted
`ifdef MC_PROCESSOR_PERF_EN
    ,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       instret
`endif
);

    localparam int AW = $clog2(NREGS);

    state_e            state_q, state_d;
    logic [31:0]       pc_q, ir_q, addr_q;
    logic              cmp_q;
    logic [DATA_W-1:0] result_q, alu_b, imm_sx;
    logic [3:0]        op, rd_f, rn_f, rm_f, ra2_f;
    logic [15:0]       imm16;

    assign op     = ir_q[OP_MSB:OP_LSB];
    assign rd_f   = ir_q[RD_MSB:RD_LSB];
    assign rn_f   = ir_q[RN_MSB:RN_LSB];
    assign rm_f   = ir_q[RM_MSB:RM_LSB];
    assign imm16  = ir_q[IMM_MSB:IMM_LSB];
    assign imm_sx = {{(DATA_W-16){imm16[15]}}, imm16};
    // STR needs the store data (rd) on the second read port.
    assign ra2_f  = (op == OP_STR) ? rd_f : rm_f;

    mc_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .AW(AW)) u_regfile (
        .clk_i  (clk),
        .rst_ni (rst),
        .ra1_i  (rn_f[AW-1:0]),
        .ra2_i  (ra2_f[AW-1:0]),
        .we_i   (state_q == ST_WB),
        .wa_i   (rd_f[AW-1:0]),
        .wd_i   (result_q),
        .rd1_o  (rd1),
        .rd2_o  (rd2)
    );

    assign alu_op = alu_op_of(op);
    assign alu_b  = (op == OP_ADDI || op == OP_LDR || op == OP_STR) ? imm_sx : rd2;

    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_ADD: alu_result = rd1 + alu_b;
            ALU_SUB: alu_result = rd1 - alu_b;
            ALU_AND: alu_result = rd1 & alu_b;
            ALU_ORR: alu_result = rd1 | alu_b;
            ALU_LSL: alu_result = rd1 << imm16[4:0];
            default: alu_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                if (op == OP_HALT)     state_d = ST_HALT;
                else if (!op_known(op)) state_d = ST_FETCH;
                else                   state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (op)
                    OP_CMP, OP_BEQ: state_d = ST_FETCH;
                    OP_LDR, OP_STR: state_d = ST_MEM;
                    default:        state_d = ST_WB;
                endcase
            end
            ST_MEM:    if (mem_ready) state_d = (op == OP_STR) ? ST_FETCH : ST_WB;
            ST_WB:     state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        halted    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
                if (op == OP_STR) begin
                    mem_we    = 1'b1;
                    mem_wdata = rd2;
                end
            end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= '0;
            ir_q     <= '0;
            addr_q   <= '0;
            cmp_q    <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                ST_FETCH:  if (mem_ready) ir_q <= mem_rdata[31:0];
                ST_DECODE: pc_q <= pc_q + 32'd4;
                ST_EXEC: begin
                    case (op)
                        OP_CMP:         cmp_q <= (rd1 == rd2);
                        OP_BEQ:         if (cmp_q) pc_q <= pc_q + {{14{imm16[15]}}, imm16, 2'b00};
                        OP_LDR, OP_STR: addr_q <= alu_result[31:0];
                        default:        result_q <= alu_result;
                    endcase
                end
                ST_MEM:    if (mem_ready && op == OP_LDR) result_q <= mem_rdata;
                default: ;
            endcase
        end
    end

    assign result  = result_q;
    assign CMPFlag = cmp_q;
    assign PC      = pc_q;
    assign state   = state_q;

`ifdef MC_PROCESSOR_PERF_EN
    logic [31:0] cycle_q, instret_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (state_q != ST_IDLE && state_q != ST_HALT) cycle_q <= cycle_q + 32'd1;
            if (state_d == ST_FETCH && state_q != ST_FETCH && state_q != ST_IDLE)
                instret_q <= instret_q + 32'd1;
        end
    end

    assign cycle_cnt = cycle_q;
    assign instret   = instret_q;
`endif

endmodule
